// File: rtl/even_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// even_parity_frame_rx
//
// Serial frame receiver feeding the even-parity checker stage. A bit-strobed
// stream of {start(0), DATA_W data bits LSB first, even-parity bit, stop(1)}
// is reassembled. The received word is then presented downstream on a
// valid/ready handshake, together with parity and framing error flags.
//
// Handshake: frame_valid rises the cycle after the stop bit is sampled. While
// frame_valid=1, data_out/parity_out/parity_err/frame_err/err_count hold
// steady. The frame is consumed on the rising clk edge where frame_valid and
// frame_ready are both 1. frame_valid never drops without that edge.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   serial_in    in   serial bit value, sampled only when serial_valid=1
//   serial_valid in   bit strobe, one bit consumed per strobed clk edge
//   data_out     out  [DATA_W-1:0] received data word
//   parity_out   out  received parity bit
//   parity_err   out  ^{parity_out, data_out}; 1 = even-parity violation
//   frame_err    out  stop bit was sampled as 0
//   frame_valid  out  frame available downstream
//   frame_ready  in   downstream accepts the frame
//   err_count    out  [7:0] saturating count of frames with parity_err=1
//
// Build option:
//   PARITY_ERR_CNT_EN  defined   -> err_count counts bad-parity frames and
//                                   saturates at 255.
//                      undefined -> err_count is tied to 0 and no counter
//                                   logic is built.
//   The port list is the same in both builds.
// -----------------------------------------------------------------------------
module even_parity_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic              serial_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              parity_err,
    output logic              frame_err,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [7:0]        err_count
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bit;

    // Datapath enables decoded by the FSM.
    logic              start_en;
    logic              shift_en;
    logic              par_en;
    logic              stop_en;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and datapath enables
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        start_en   = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;

        case (state)
            IDLE: begin
                // A strobed 1 is line idle; only a strobed 0 starts a frame.
                if (serial_valid && !serial_in) begin
                    start_en   = 1'b1;
                    state_next = DATA;
                end
            end

            DATA: begin
                if (serial_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = PARITY;
                    end
                end
            end

            PARITY: begin
                if (serial_valid) begin
                    par_en     = 1'b1;
                    state_next = STOP;
                end
            end

            STOP: begin
                if (serial_valid) begin
                    stop_en    = 1'b1;
                    state_next = HOLD;
                end
            end

            HOLD: begin
                // Strobes are ignored here, including one that arrives in the
                // handshake cycle. The line must be re-armed from IDLE.
                if (frame_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // HOLD is the only state that presents a frame. Decoding it from the
    // registered state keeps frame_valid a clean register output.
    assign frame_valid = (state == HOLD);

    // -------------------------------------------------------------------------
    // Datapath: bit counter, shift register, captured parity, output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            parity_out <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (start_en) begin
                bit_cnt <= '0;
            end

            if (shift_en) begin
                // LSB first: bit k of the frame lands at index k.
                shift_reg[bit_cnt] <= serial_in;
                bit_cnt            <= bit_cnt + CNT_W'(1);
            end

            if (par_en) begin
                par_bit <= serial_in;
            end

            // The output registers load only on the stop strobe. They stay
            // frozen through HOLD and until the next frame completes.
            if (stop_en) begin
                data_out   <= shift_reg;
                parity_out <= par_bit;
                frame_err  <= ~serial_in;
            end
        end
    end

    // Derived from the registered outputs only, so it is exactly what the
    // downstream checker computes on {parity_out, data_out}.
    assign parity_err = ^{parity_out, data_out};

    // -------------------------------------------------------------------------
    // Bad-parity frame counter
    // -------------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
    // Parity of the frame being latched on this edge. It is looked at only
    // when stop_en=1, which is the edge that enters HOLD.
    logic frame_bad;
    assign frame_bad = ^{par_bit, shift_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'h00;
        end else if (stop_en && frame_bad && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_even_parity_frame_rx
//
// Directed-vector bench for even_parity_frame_rx (DATA_W=8). The driver pushes
// an expected frame record {data, parity, parity_err, frame_err, err_count}
// into exp_q when it strobes a stop bit that should produce a frame. A monitor
// on the falling edge compares every cycle in which frame_valid is high
// against the queue head, and pops on the handshake. It also checks reset
// values in every cycle that follows a reset edge, and runs the end-of-test
// checks.
// -----------------------------------------------------------------------------
module tb_even_parity_frame_rx;

    localparam int EXP_W = 19;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       serial_valid;
    logic [7:0] data_out;
    logic       parity_out;
    logic       parity_err;
    logic       frame_err;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] err_count;

    logic [EXP_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [7:0]       model_cnt = 8'h00;
    logic             done = 1'b0;
    logic             final_done = 1'b0;
    logic             rst_q = 1'b0;

    even_parity_frame_rx #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (data_out),
        .parity_out   (parity_out),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .err_count    (err_count)
    );

    // ---------------- clock / reset tracking ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rst_q=1 means the last rising edge applied reset.
    always @(posedge clk) rst_q <= rst;

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        serial_in    = b;
        serial_valid = 1'b1;
        @(posedge clk);
        #1;
        serial_valid = 1'b0;
        serial_in    = 1'b1;
        idle(gap);
    endtask

    // exp_perr / exp_ferr are hand-computed for each vector by the caller.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int gap, input logic exp_perr,
                              input logic exp_ferr, input logic record);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        if (record) begin
`ifdef PARITY_ERR_CNT_EN
            if (exp_perr && model_cnt != 8'hFF) model_cnt = model_cnt + 8'h01;
`endif
            exp_q.push_back({d, p, exp_perr, exp_ferr, model_cnt});
        end
        send_bit(s, gap);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_q) begin
            checks++;
            if ({data_out, parity_out, parity_err, frame_err, frame_valid, err_count} !== 20'h0) begin
                errors++;
                $display("FAIL reset_values: got data=%h par=%b perr=%b ferr=%b valid=%b cnt=%0d, required all zero",
                         data_out, parity_out, parity_err, frame_err, frame_valid, err_count);
            end
        end else if (frame_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid: got frame_valid=1 data=%h at %0t, required no frame", data_out, $time);
            end else begin
                if ({data_out, parity_out, parity_err, frame_err, err_count} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL frame: got data=%h par=%b perr=%b ferr=%b cnt=%0d, required data=%h par=%b perr=%b ferr=%b cnt=%0d",
                             data_out, parity_out, parity_err, frame_err, err_count,
                             exp_q[0][18:11], exp_q[0][10], exp_q[0][9], exp_q[0][8], exp_q[0][7:0]);
                end
                if (frame_ready) void'(exp_q.pop_front());
            end
        end

        if (done && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL queue_drain: got %0d frames never delivered, required 0", exp_q.size());
            end
            checks++;
            if (err_count !== model_cnt) begin
                errors++;
                $display("FAIL final_err_count: got %0d, required %0d", err_count, model_cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        serial_in    = 1'b1;
        serial_valid = 1'b0;
        frame_ready  = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Good frame: 0xA5 has four ones, parity 0 is correct.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Bad parity: 0x01 has one one, so parity 0 is wrong.
        send_frame(8'h01, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
        idle(2);
        // Framing error: 0x3C parity ok, stop bit 0.
        send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle(2);
        // Odd-weight byte with a correct parity 1.
        send_frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Back-pressure: hold 0x81 while 0xFF is strobed in. 0xFF must be
        // discarded, and 0x0F after the handshake must be received.
        frame_ready = 1'b0;
        send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        frame_ready = 1'b1;
        idle(2);
        send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Idle-line strobes, then a slow frame with 3 idle cycles per bit.
        repeat (5) send_bit(1'b1, 0);
        send_frame(8'hC3, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset after 4 data bits of an abandoned frame.
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_cnt = 8'h00;
        idle(2);
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 300 bad-parity frames back to back: the counter saturates at 255
        // when PARITY_ERR_CNT_EN is defined, and stays 0 otherwise.
        for (int n = 0; n < 300; n++) begin
            send_frame(8'h01, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
            idle(1);
        end
        idle(3);

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
